// File: rtl/pic_int_sequencer_if.sv
// Bus bundle between the PIC control logic / IR pins and the interrupt sequencing core.
// The core connects through the slave modport; the control side uses master.
interface pic_int_sequencer_if;
   logic [7:0] ir;
   logic [7:0] imr;
   logic       ltim;
   logic       aeoi;
   logic       rot_aeoi;
   logic [4:0] vec_base;
   logic       inta_stb;
   logic       eoi_stb;
   logic       eoi_spec;
   logic       eoi_rot;
   logic [2:0] eoi_lvl;
   logic       setpri_stb;
   logic       int_out;
   logic [7:0] vec_out;
   logic       vec_oe;
   logic [7:0] irr;
   logic [7:0] isr;

   modport master (
      output ir, imr, ltim, aeoi, rot_aeoi, vec_base, inta_stb,
             eoi_stb, eoi_spec, eoi_rot, eoi_lvl, setpri_stb,
      input  int_out, vec_out, vec_oe, irr, isr
   );

   modport slave (
      input  ir, imr, ltim, aeoi, rot_aeoi, vec_base, inta_stb,
             eoi_stb, eoi_spec, eoi_rot, eoi_lvl, setpri_stb,
      output int_out, vec_out, vec_oe, irr, isr
   );
endinterface

// File: rtl/pic_int_sequencer.sv
// PIC interrupt sequencing core: IRR/ISR, rotating priority resolver,
// two-strobe INTA handshake and EOI/rotation handling.
//
// state  | meaning
// S_IDLE | no request to CPU; waiting for a pending level
// S_REQ  | int_out high; waiting for first INTA strobe
// S_ACK1 | level frozen in ack_lvl; waiting for second INTA strobe to drive vector
module pic_int_sequencer (
   input  logic                       clk,
   input  logic                       rst_n,
   pic_int_sequencer_if.slave         bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_ACK1 = 2'd2;

   logic [1:0] r_state;
   logic [7:0] r_irr;
   logic [7:0] r_isr;
   logic [7:0] r_ir_prev;
   logic [2:0] r_lp;
   logic [2:0] r_ack_lvl;
   logic       r_spur;
   logic       r_int_out;
   logic [7:0] r_vec_out;
   logic       r_vec_oe;

   logic [7:0] w_elig;
   logic [3:0] w_cand_res;
   logic [3:0] w_isr_res;
   logic       w_cand_vld;
   logic [2:0] w_cand;
   logic       w_isr_vld;
   logic [2:0] w_isr_hi;
   logic       w_pending;

   logic [1:0] w_state_nxt;
   logic [2:0] w_ack_nxt;
   logic       w_spur_nxt;
   logic [7:0] w_isr_set;
   logic [7:0] w_isr_clr;
   logic [7:0] w_irr_ack;
   logic [7:0] w_irr_nxt;
   logic [2:0] w_lp_nxt;
   logic       w_vec_load;

   // Returns {valid, level} of the highest-priority set bit; level lp+1 ranks first.
   function automatic logic [3:0] f_resolve(input logic [7:0] v, input logic [2:0] lp);
      logic [3:0] res;
      logic [2:0] lvl;
      res = 4'b0000;
      for (int i = 8; i >= 1; i--) begin
         lvl = lp + 3'(i);
         if (v[lvl]) res = {1'b1, lvl};
      end
      return res;
   endfunction

   function automatic logic [2:0] f_rank(input logic [2:0] lvl, input logic [2:0] lp);
      return lvl - lp - 3'd1;
   endfunction

   assign w_elig     = r_irr & ~bus.imr;
   assign w_cand_res = f_resolve(w_elig, r_lp);
   assign w_isr_res  = f_resolve(r_isr, r_lp);
   assign w_cand_vld = w_cand_res[3];
   assign w_cand     = w_cand_res[2:0];
   assign w_isr_vld  = w_isr_res[3];
   assign w_isr_hi   = w_isr_res[2:0];
   assign w_pending  = w_cand_vld &&
                       (!w_isr_vld || (f_rank(w_cand, r_lp) < f_rank(w_isr_hi, r_lp)));

   always_comb begin
      w_state_nxt = r_state;
      w_ack_nxt   = r_ack_lvl;
      w_spur_nxt  = r_spur;
      w_isr_set   = 8'h00;
      w_isr_clr   = 8'h00;
      w_irr_ack   = 8'h00;
      w_lp_nxt    = r_lp;
      w_vec_load  = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (bus.inta_stb) begin
               w_state_nxt = S_ACK1;
               w_ack_nxt   = 3'd7;
               w_spur_nxt  = 1'b1;
            end else if (w_pending) begin
               w_state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            if (bus.inta_stb) begin
               w_state_nxt = S_ACK1;
               if (w_cand_vld) begin
                  w_ack_nxt  = w_cand;
                  w_spur_nxt = 1'b0;
                  w_isr_set  = 8'd1 << w_cand;
                  w_irr_ack  = 8'd1 << w_cand;
               end else begin
                  w_ack_nxt  = 3'd7;
                  w_spur_nxt = 1'b1;
               end
            end
         end
         S_ACK1: begin
            if (bus.inta_stb) begin
               w_state_nxt = S_IDLE;
               w_vec_load  = 1'b1;
               if (bus.aeoi && !r_spur) begin
                  w_isr_clr = 8'd1 << r_ack_lvl;
                  if (bus.rot_aeoi) w_lp_nxt = r_ack_lvl;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      if (bus.eoi_stb) begin
         if (bus.eoi_spec) begin
            w_isr_clr = w_isr_clr | (8'd1 << bus.eoi_lvl);
            if (bus.eoi_rot) w_lp_nxt = bus.eoi_lvl;
         end else if (w_isr_vld) begin
            w_isr_clr = w_isr_clr | (8'd1 << w_isr_hi);
            if (bus.eoi_rot) w_lp_nxt = w_isr_hi;
         end
      end

      if (bus.setpri_stb) w_lp_nxt = bus.eoi_lvl;
   end

   // Edge mode: a new rising edge sets; a low input or an acknowledge clears.
   always_comb begin
      w_irr_nxt = 8'h00;
      if (bus.ltim) w_irr_nxt = bus.ir;
      else          w_irr_nxt = (r_irr & bus.ir & ~w_irr_ack) | (bus.ir & ~r_ir_prev);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_irr     <= 8'h00;
         r_isr     <= 8'h00;
         r_ir_prev <= 8'h00;
         r_lp      <= 3'd7;
         r_ack_lvl <= 3'd7;
         r_spur    <= 1'b0;
         r_int_out <= 1'b0;
         r_vec_out <= 8'h00;
         r_vec_oe  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_irr     <= w_irr_nxt;
         r_isr     <= (r_isr & ~w_isr_clr) | w_isr_set;
         r_ir_prev <= bus.ir;
         r_lp      <= w_lp_nxt;
         r_ack_lvl <= w_ack_nxt;
         r_spur    <= w_spur_nxt;
         r_int_out <= (w_state_nxt == S_REQ);
         r_vec_oe  <= w_vec_load;
         if (w_vec_load) r_vec_out <= {bus.vec_base, r_ack_lvl};
      end
   end

   assign bus.int_out = r_int_out;
   assign bus.vec_out = r_vec_out;
   assign bus.vec_oe  = r_vec_oe;
   assign bus.irr     = r_irr;
   assign bus.isr     = r_isr;

endmodule

// File: tb/tb_pic_int_sequencer.sv
// Directed bench for pic_int_sequencer: a level-mode priority table plus
// hand-written edge-mode handshake, nesting, AEOI, spurious and reset sequences.
module tb_pic_int_sequencer;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_err;

   pic_int_sequencer_if bus ();

   pic_int_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] lp;
      logic [7:0] ir;
      logic [7:0] imr;
      logic       exp_int;
      logic [2:0] exp_lvl;
      logic [7:0] exp_isr;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic inta();
      bus.inta_stb = 1'b1;
      step(1);
      bus.inta_stb = 1'b0;
   endtask

   task automatic do_reset();
      bus.ir = 8'h00; bus.imr = 8'h00; bus.ltim = 1'b0; bus.aeoi = 1'b0;
      bus.rot_aeoi = 1'b0; bus.inta_stb = 1'b0; bus.eoi_stb = 1'b0;
      bus.eoi_spec = 1'b0; bus.eoi_rot = 1'b0; bus.eoi_lvl = 3'd0;
      bus.setpri_stb = 1'b0;
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk = 0;
      n_err = 0;
      bus.vec_base = 5'b10101;

      //          lp    ir     imr    int   lvl   isr
      tbl[0] = '{3'd7, 8'h01, 8'h00, 1'b1, 3'd0, 8'h01};
      tbl[1] = '{3'd7, 8'h0C, 8'h00, 1'b1, 3'd2, 8'h04};
      tbl[2] = '{3'd7, 8'h0C, 8'h04, 1'b1, 3'd3, 8'h08};
      tbl[3] = '{3'd7, 8'h80, 8'h80, 1'b0, 3'd7, 8'h00};
      tbl[4] = '{3'd3, 8'h09, 8'h00, 1'b1, 3'd0, 8'h01};
      tbl[5] = '{3'd3, 8'h18, 8'h00, 1'b1, 3'd4, 8'h10};
      tbl[6] = '{3'd0, 8'h03, 8'h00, 1'b1, 3'd1, 8'h02};
      tbl[7] = '{3'd6, 8'hC0, 8'h00, 1'b1, 3'd7, 8'h80};
      tbl[8] = '{3'd7, 8'h00, 8'h00, 1'b0, 3'd7, 8'h00};
      tbl[9] = '{3'd5, 8'h61, 8'h00, 1'b1, 3'd6, 8'h40};

      // Reset state
      rst_n = 1'b0;
      bus.ir = 8'h00; bus.imr = 8'h00; bus.ltim = 1'b0; bus.aeoi = 1'b0;
      bus.rot_aeoi = 1'b0; bus.inta_stb = 1'b0; bus.eoi_stb = 1'b0;
      bus.eoi_spec = 1'b0; bus.eoi_rot = 1'b0; bus.eoi_lvl = 3'd0;
      bus.setpri_stb = 1'b0;
      step(2);
      chk("rst_int",    {7'd0, bus.int_out}, 8'h00);
      chk("rst_vec",    bus.vec_out,         8'h00);
      chk("rst_vec_oe", {7'd0, bus.vec_oe},  8'h00);
      chk("rst_irr",    bus.irr,             8'h00);
      chk("rst_isr",    bus.isr,             8'h00);

      // Level-mode priority table
      for (int r = 0; r < 10; r++) begin
         do_reset();
         bus.ltim = 1'b1;
         bus.eoi_lvl = tbl[r].lp;
         bus.setpri_stb = 1'b1;
         step(1);
         bus.setpri_stb = 1'b0;
         bus.ir  = tbl[r].ir;
         bus.imr = tbl[r].imr;
         step(1);
         chk($sformatf("tbl%0d_irr", r), bus.irr, tbl[r].ir);
         step(1);
         chk($sformatf("tbl%0d_int", r), {7'd0, bus.int_out}, {7'd0, tbl[r].exp_int});
         inta();
         chk($sformatf("tbl%0d_int_ack", r), {7'd0, bus.int_out}, 8'h00);
         chk($sformatf("tbl%0d_isr", r), bus.isr, tbl[r].exp_isr);
         inta();
         chk($sformatf("tbl%0d_vec_oe", r), {7'd0, bus.vec_oe}, 8'h01);
         chk($sformatf("tbl%0d_vec", r), bus.vec_out, {5'b10101, tbl[r].exp_lvl});
         step(1);
         chk($sformatf("tbl%0d_vec_oe_off", r), {7'd0, bus.vec_oe}, 8'h00);
      end

      bus.vec_base = 5'b01000;

      // A: edge mode, single request on level 3
      do_reset();
      bus.vec_base = 5'b01000;
      bus.ir = 8'h08;
      step(1);
      chk("a_irr", bus.irr, 8'h08);
      chk("a_int_early", {7'd0, bus.int_out}, 8'h00);
      step(1);
      chk("a_int", {7'd0, bus.int_out}, 8'h01);
      inta();
      chk("a_int_fall", {7'd0, bus.int_out}, 8'h00);
      chk("a_isr", bus.isr, 8'h08);
      chk("a_irr_clr", bus.irr, 8'h00);
      inta();
      chk("a_vec_oe", {7'd0, bus.vec_oe}, 8'h01);
      chk("a_vec", bus.vec_out, 8'h43);
      step(1);
      chk("a_vec_oe_off", {7'd0, bus.vec_oe}, 8'h00);
      chk("a_vec_hold", bus.vec_out, 8'h43);
      bus.ir = 8'h00;

      // B: two levels together, non-specific EOI then second level
      do_reset();
      bus.ir = 8'h24;
      step(2);
      chk("b_int", {7'd0, bus.int_out}, 8'h01);
      inta();
      chk("b_isr", bus.isr, 8'h04);
      inta();
      chk("b_vec", bus.vec_out, 8'h42);
      chk("b_int_nested", {7'd0, bus.int_out}, 8'h00);
      bus.eoi_stb = 1'b1;
      step(1);
      bus.eoi_stb = 1'b0;
      chk("b_isr_eoi", bus.isr, 8'h00);
      chk("b_int_eoi", {7'd0, bus.int_out}, 8'h00);
      step(1);
      chk("b_int_re", {7'd0, bus.int_out}, 8'h01);
      inta();
      chk("b_isr5", bus.isr, 8'h20);
      inta();
      chk("b_vec5", bus.vec_out, 8'h45);

      // C: nesting under level 4
      do_reset();
      bus.ir = 8'h10;
      step(2);
      inta();
      inta();
      chk("c_isr4", bus.isr, 8'h10);
      bus.ir = 8'h50;
      step(3);
      chk("c_irr6", bus.irr, 8'h40);
      chk("c_int_blocked", {7'd0, bus.int_out}, 8'h00);
      bus.ir = 8'h52;
      step(2);
      chk("c_int_nest", {7'd0, bus.int_out}, 8'h01);
      inta();
      chk("c_isr12", bus.isr, 8'h12);
      inta();
      chk("c_vec1", bus.vec_out, 8'h41);

      // D: automatic EOI with rotation
      do_reset();
      bus.aeoi = 1'b1;
      bus.rot_aeoi = 1'b1;
      bus.ir = 8'h01;
      step(2);
      chk("d_int", {7'd0, bus.int_out}, 8'h01);
      inta();
      chk("d_isr_set", bus.isr, 8'h01);
      inta();
      chk("d_vec0", bus.vec_out, 8'h40);
      chk("d_isr_aeoi", bus.isr, 8'h00);
      bus.ir = 8'h00;
      step(1);
      bus.ir = 8'h03;
      step(2);
      chk("d_int2", {7'd0, bus.int_out}, 8'h01);
      inta();
      chk("d_isr_l1", bus.isr, 8'h02);
      inta();
      chk("d_vec_rot", bus.vec_out, 8'h41);
      chk("d_isr_aeoi2", bus.isr, 8'h00);
      step(1);
      chk("d_int3", {7'd0, bus.int_out}, 8'h01);
      inta();
      inta();
      chk("d_vec_l0", bus.vec_out, 8'h40);
      bus.aeoi = 1'b0;
      bus.rot_aeoi = 1'b0;

      // E: spurious after masking the requester
      do_reset();
      bus.ir = 8'h04;
      step(2);
      chk("e_int", {7'd0, bus.int_out}, 8'h01);
      bus.imr = 8'h04;
      step(1);
      chk("e_int_held", {7'd0, bus.int_out}, 8'h01);
      inta();
      chk("e_isr1", bus.isr, 8'h00);
      inta();
      chk("e_vec", bus.vec_out, 8'h47);
      chk("e_isr2", bus.isr, 8'h00);
      bus.ir = 8'h00;
      step(1);
      bus.imr = 8'h00;

      // F: reset between the two INTA strobes
      do_reset();
      bus.ir = 8'h08;
      step(2);
      inta();
      chk("f_isr", bus.isr, 8'h08);
      rst_n = 1'b0;
      #1;
      chk("f_int_rst", {7'd0, bus.int_out}, 8'h00);
      chk("f_isr_rst", bus.isr, 8'h00);
      chk("f_irr_rst", bus.irr, 8'h00);
      bus.ir = 8'h00;
      step(1);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step(1);
         chk($sformatf("f_vec_oe_%0d", k), {7'd0, bus.vec_oe}, 8'h00);
         chk($sformatf("f_int_%0d", k), {7'd0, bus.int_out}, 8'h00);
      end
      bus.ir = 8'h02;
      step(2);
      chk("f_int_new", {7'd0, bus.int_out}, 8'h01);
      inta();
      chk("f_vec_oe_mid", {7'd0, bus.vec_oe}, 8'h00);
      inta();
      chk("f_vec_oe", {7'd0, bus.vec_oe}, 8'h01);
      chk("f_vec", bus.vec_out, 8'h41);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
